game_controller: RTL and testbench
==================================

GAME_CONTROLLER -- requirements
Module: game_controller

Interface
REQ-001 Parameter TICK_DIV, default 1000000, SHALL set the clk cycles per game tick (100 Hz at 100 MHz).
REQ-002 Parameter READY_TICKS, default 120, SHALL set the ticks spent in READY and in LEVEL_CLEAR.
REQ-003 Parameter DEATH_TICKS, default 90, SHALL set the ticks spent in DYING.
REQ-004 Parameter FRIGHT_TICKS, default 600, SHALL set the frightened-mode duration in ticks.
REQ-005 Parameter LIVES, default 3, SHALL set the lives loaded at game start (1..3).
REQ-006 Parameter DOTS_TOTAL, default 244, SHALL set the dots per level (1..65535).
REQ-007 Port clk, input, 1, SHALL be the system clock; all logic is on its rising edge.
REQ-008 Port reset, input, 1: one clock; reset is asynchronous and active-high.
REQ-009 Port start, input, 1, SHALL be a single-cycle start pulse (debounced SCEN).
REQ-010 Port pause, input, 1, SHALL be a single-cycle pause-toggle pulse.
REQ-011 Port dot_eaten, input, 1, SHALL be a single-cycle pulse from pacman_movement for a normal dot.
REQ-012 Port power_eaten, input, 1, SHALL be a single-cycle pulse for a power pellet.
REQ-013 Port ghost_hit, input, 1, SHALL be a level that is high while pacman overlaps any ghost.
REQ-014 Port state, output, 3, SHALL be the FSM encoding: IDLE=0, READY=1, PLAY=2, PAUSED=3, DYING=4, LEVEL_CLEAR=5, GAME_OVER=6.
REQ-015 Port pac_move_en, output, 1, SHALL be a one-cycle pacman step strobe.
REQ-016 Port ghost_move_en, output, 1, SHALL be a one-cycle ghost step strobe.
REQ-017 Port frightened, output, 1, SHALL be high while ghosts are edible.
REQ-018 Port score, output, 16, SHALL be the binary score.
REQ-019 Port lives, output, 2, SHALL be the remaining lives.
REQ-020 Port level, output, 4, SHALL be the current level.
REQ-021 Port dots_left, output, 16, SHALL be the dots remaining.

Function
REQ-022 Tick divider SHALL count 0..TICK_DIV-1 free-running in every state; tick is high for one cycle when the count wraps.
REQ-023 IDLE/GAME_OVER + start SHALL load score=0, lives=LIVES, level=1, dots_left=DOTS_TOTAL, frightened=0, phase counter=READY_TICKS, and enter READY next cycle.
REQ-024 READY and LEVEL_CLEAR SHALL decrement the phase counter on each tick; at zero, READY enters PLAY and LEVEL_CLEAR enters READY (reload READY_TICKS).
REQ-025 PLAY on tick SHALL assert pac_move_en for exactly that cycle; ghost_move_en SHALL assert on every tick when frightened=0 and every second tick when frightened=1.
REQ-026 Strobes SHALL never assert outside PLAY.
REQ-027 dot_eaten in PLAY SHALL add 10 to score and decrement dots_left.
REQ-028 power_eaten in PLAY SHALL add 50 to score, decrement dots_left, set frightened=1 and reload the fright counter to FRIGHT_TICKS (restart if already frightened).
REQ-029 dot_eaten and power_eaten in the same cycle SHALL count once, as power_eaten.
REQ-030 Eat pulses with dots_left=0 or outside PLAY SHALL be ignored.
REQ-031 Score SHALL saturate at 16'hFFFF.
REQ-032 Fright counter SHALL decrement on PLAY ticks only; at zero, frightened clears.
REQ-033 ghost_hit with frightened=1 SHALL add 200 once per rising edge of ghost_hit, with no state change.
REQ-034 ghost_hit with frightened=0 in PLAY SHALL enter DYING with counter=DEATH_TICKS and frightened cleared.
REQ-035 dots_left reaching 0 SHALL enter LEVEL_CLEAR the next cycle with counter=READY_TICKS.
REQ-036 LEVEL_CLEAR exit SHALL increment level (saturate 15) and reload dots_left=DOTS_TOTAL.
REQ-037 PLAY-exit priority in one cycle SHALL be: death hit > level clear > pause.
REQ-038 pause in PLAY SHALL enter PAUSED; pause in PAUSED SHALL return to PLAY. All counters except the tick divider SHALL freeze in PAUSED.
REQ-039 DYING at zero SHALL apply the following: if lives=1, set lives=0 and enter GAME_OVER; else decrement lives and enter READY with READY_TICKS.
REQ-040 start SHALL be ignored in READY, PLAY, PAUSED, DYING and LEVEL_CLEAR.

Reset
REQ-041 reset SHALL immediately, at any time including mid-state, force state=IDLE, score=0, lives=0, level=0, dots_left=0, frightened=0, strobes=0, and all counters 0.

Verification (TICK_DIV=4, READY_TICKS=2, DEATH_TICKS=2, FRIGHT_TICKS=4, LIVES=2, DOTS_TOTAL=3)
REQ-042 Sequence start, then wait 2 ticks -> state 1 then 2, lives=2, level=1, dots_left=3, with pac_move_en pulses every 4 cycles.
REQ-043 Sequence power_eaten, then dot_eaten -> score=60, dots_left=1, frightened=1, ghost_move_en every 8 cycles, and frightened clears after 4 ticks.
REQ-044 While frightened, hold ghost_hit 3 cycles -> score +200 once; state stays 2.
REQ-045 ghost_hit and pause in the same unfrightened cycle -> DYING, then READY with lives=1; a second death -> GAME_OVER with lives=0.
REQ-046 Eat the last dot -> LEVEL_CLEAR, then READY with level=2 and dots_left=3; a pause pulse freezes the counters.
REQ-047 Assert reset while in PAUSED -> all outputs 0 within the same cycle.

Source files
------------

// File: rtl/game_controller.sv
// Game sequencer: tick divider, READY/PLAY/PAUSED/DYING/LEVEL_CLEAR/GAME_OVER FSM, score, lives, level, dot and fright bookkeeping.
// Registered state; move strobes are combinational from the divider wrap in PLAY; no backpressure, and eat/hit pulses are never stalled.
module game_controller #(
    parameter int TICK_DIV     = 1000000,
    parameter int READY_TICKS  = 120,
    parameter int DEATH_TICKS  = 90,
    parameter int FRIGHT_TICKS = 600,
    parameter int LIVES        = 3,
    parameter int DOTS_TOTAL   = 244
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        pause,
    input  logic        dot_eaten,
    input  logic        power_eaten,
    input  logic        ghost_hit,
    output logic [2:0]  state,
    output logic        pac_move_en,
    output logic        ghost_move_en,
    output logic        frightened,
    output logic [15:0] score,
    output logic [1:0]  lives,
    output logic [3:0]  level,
    output logic [15:0] dots_left
);
    localparam int DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int PH_MAX = (READY_TICKS > DEATH_TICKS) ? READY_TICKS : DEATH_TICKS;
    localparam int PH_W   = (PH_MAX > 0) ? $clog2(PH_MAX + 1) : 1;
    localparam int FR_W   = (FRIGHT_TICKS > 0) ? $clog2(FRIGHT_TICKS + 1) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(TICK_DIV - 1);
    localparam logic [PH_W-1:0]  READY_LD  = PH_W'(READY_TICKS);
    localparam logic [PH_W-1:0]  DEATH_LD  = PH_W'(DEATH_TICKS);
    localparam logic [FR_W-1:0]  FRIGHT_LD = FR_W'(FRIGHT_TICKS);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        READY       = 3'd1,
        PLAY        = 3'd2,
        PAUSED      = 3'd3,
        DYING       = 3'd4,
        LEVEL_CLEAR = 3'd5,
        GAME_OVER   = 3'd6
    } state_t;

    state_t          cur_state, nxt_state;
    logic [DIV_W-1:0] div_cnt;
    logic [PH_W-1:0]  phase_cnt, phase_nxt;
    logic [FR_W-1:0]  fright_cnt, fright_nxt;
    logic             frightened_nxt;
    logic [15:0]      score_nxt, dots_nxt;
    logic [1:0]       lives_nxt;
    logic [3:0]       level_nxt;
    logic             ghost_alt, alt_nxt;
    logic             ghost_hit_d;
    logic             tick, in_play, eat_power, eat_dot, ghost_bonus, death;
    logic [16:0]      add_pts, score_sum;

    assign state         = cur_state;
    assign tick          = (div_cnt == DIV_LAST);
    assign in_play       = (cur_state == PLAY);
    assign pac_move_en   = in_play && tick;
    // Frightened ghosts step only on alternate ticks.
    assign ghost_move_en = in_play && tick && (!frightened || ghost_alt);
    assign eat_power     = in_play && power_eaten && (dots_left != 16'd0);
    assign eat_dot       = in_play && dot_eaten && !power_eaten && (dots_left != 16'd0);
    assign ghost_bonus   = in_play && frightened && ghost_hit && !ghost_hit_d;
    assign death         = in_play && ghost_hit && !frightened;

    always_comb begin
        add_pts = 17'd0;
        if (eat_power)
            add_pts = 17'd50;
        else if (eat_dot)
            add_pts = 17'd10;
        if (ghost_bonus)
            add_pts = add_pts + 17'd200;
        score_sum = {1'b0, score} + add_pts;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            div_cnt <= '0;
        else if (tick)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + DIV_W'(1);
    end

    always_comb begin
        nxt_state      = cur_state;
        phase_nxt      = phase_cnt;
        fright_nxt     = fright_cnt;
        frightened_nxt = frightened;
        score_nxt      = score;
        lives_nxt      = lives;
        level_nxt      = level;
        dots_nxt       = dots_left;
        alt_nxt        = ghost_alt;
        case (cur_state)
            IDLE, GAME_OVER: begin
                if (start) begin
                    score_nxt      = 16'd0;
                    lives_nxt      = 2'(LIVES);
                    level_nxt      = 4'd1;
                    dots_nxt       = 16'(DOTS_TOTAL);
                    frightened_nxt = 1'b0;
                    fright_nxt     = '0;
                    phase_nxt      = READY_LD;
                    nxt_state      = READY;
                end
            end
            READY: begin
                if (tick) begin
                    if (phase_cnt <= PH_W'(1)) begin
                        phase_nxt = '0;
                        nxt_state = PLAY;
                    end else begin
                        phase_nxt = phase_cnt - PH_W'(1);
                    end
                end
            end
            PLAY: begin
                score_nxt = score_sum[16] ? 16'hFFFF : score_sum[15:0];
                if (eat_power || eat_dot)
                    dots_nxt = dots_left - 16'd1;
                if (tick)
                    alt_nxt = !ghost_alt;
                if (eat_power) begin
                    frightened_nxt = 1'b1;
                    fright_nxt     = FRIGHT_LD;
                end else if (tick && frightened) begin
                    if (fright_cnt <= FR_W'(1)) begin
                        fright_nxt     = '0;
                        frightened_nxt = 1'b0;
                    end else begin
                        fright_nxt = fright_cnt - FR_W'(1);
                    end
                end
                // Exit priority: death, then level clear, then pause.
                if (death) begin
                    nxt_state      = DYING;
                    phase_nxt      = DEATH_LD;
                    frightened_nxt = 1'b0;
                    fright_nxt     = '0;
                end else if (dots_left == 16'd0) begin
                    nxt_state = LEVEL_CLEAR;
                    phase_nxt = READY_LD;
                end else if (pause) begin
                    nxt_state = PAUSED;
                end
            end
            PAUSED: begin
                if (pause)
                    nxt_state = PLAY;
            end
            DYING: begin
                if (tick) begin
                    if (phase_cnt <= PH_W'(1)) begin
                        if (lives <= 2'd1) begin
                            lives_nxt = 2'd0;
                            phase_nxt = '0;
                            nxt_state = GAME_OVER;
                        end else begin
                            lives_nxt = lives - 2'd1;
                            phase_nxt = READY_LD;
                            nxt_state = READY;
                        end
                    end else begin
                        phase_nxt = phase_cnt - PH_W'(1);
                    end
                end
            end
            LEVEL_CLEAR: begin
                if (tick) begin
                    if (phase_cnt <= PH_W'(1)) begin
                        level_nxt = (level == 4'd15) ? level : level + 4'd1;
                        dots_nxt  = 16'(DOTS_TOTAL);
                        phase_nxt = READY_LD;
                        nxt_state = READY;
                    end else begin
                        phase_nxt = phase_cnt - PH_W'(1);
                    end
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state   <= IDLE;
            phase_cnt   <= '0;
            fright_cnt  <= '0;
            frightened  <= 1'b0;
            score       <= 16'd0;
            lives       <= 2'd0;
            level       <= 4'd0;
            dots_left   <= 16'd0;
            ghost_alt   <= 1'b0;
            ghost_hit_d <= 1'b0;
        end else begin
            cur_state   <= nxt_state;
            phase_cnt   <= phase_nxt;
            fright_cnt  <= fright_nxt;
            frightened  <= frightened_nxt;
            score       <= score_nxt;
            lives       <= lives_nxt;
            level       <= level_nxt;
            dots_left   <= dots_nxt;
            ghost_alt   <= alt_nxt;
            ghost_hit_d <= ghost_hit;
        end
    end
endmodule

// File: tb/tb_game_controller.sv
// Directed bench for game_controller with a 4-cycle tick; k counts cycles since reset release,
// so the divider phase at each sample is k mod 4 and a tick is visible when that is 3.
module tb_game_controller;
    logic        clk = 1'b0;
    logic        reset, start, pause, dot_eaten, power_eaten, ghost_hit;
    logic [2:0]  state;
    logic        pac_move_en, ghost_move_en, frightened;
    logic [15:0] score, dots_left;
    logic [1:0]  lives;
    logic [3:0]  level;

    int tests_run    = 0;
    int tests_failed = 0;
    int k            = 0;
    int gcount       = 0;

    game_controller #(
        .TICK_DIV(4), .READY_TICKS(2), .DEATH_TICKS(2),
        .FRIGHT_TICKS(4), .LIVES(2), .DOTS_TOTAL(3)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .pause(pause),
        .dot_eaten(dot_eaten), .power_eaten(power_eaten), .ghost_hit(ghost_hit),
        .state(state), .pac_move_en(pac_move_en), .ghost_move_en(ghost_move_en),
        .frightened(frightened), .score(score), .lives(lives), .level(level),
        .dots_left(dots_left)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic wait_state(input logic [2:0] target, input int limit);
        int n = 0;
        while (state !== target && n < limit) begin
            step();
            n++;
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; pause = 1'b0;
        dot_eaten = 1'b0; power_eaten = 1'b0; ghost_hit = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        k = 0;

        check_val("rst_state", state, 0);
        check_val("rst_score", score, 0);
        check_val("rst_lives", lives, 0);
        check_val("rst_level", level, 0);
        check_val("rst_dots", dots_left, 0);
        check_val("rst_fright", frightened, 0);
        check_val("rst_pac", pac_move_en, 0);

        // Start: READY at k=1, PLAY after two ticks (k=3, k=7) -> k=8
        start = 1'b1; step(); start = 1'b0;
        check_val("start_state", state, 1);
        check_val("start_lives", lives, 2);
        check_val("start_level", level, 1);
        check_val("start_dots", dots_left, 3);
        wait_state(3'd2, 20);
        check_val("ready_exit_k", k, 8);

        while (k < 16) begin
            check_val($sformatf("pac@%0d", k), pac_move_en, (k % 4 == 3));
            check_val($sformatf("ghost@%0d", k), ghost_move_en, (k % 4 == 3));
            step();
        end

        power_eaten = 1'b1; step(); power_eaten = 1'b0;
        check_val("power_score", score, 50);
        check_val("power_fright", frightened, 1);
        dot_eaten = 1'b1; step(); dot_eaten = 1'b0;
        check_val("dot_score", score, 60);
        check_val("dot_dots", dots_left, 1);

        // Frightened until tick at k=31; ghosts step at k=23 and k=31 only; bonus once for 3-cycle hit
        while (k < 32) begin
            ghost_hit = (k >= 18 && k <= 20);
            check_val($sformatf("frt@%0d", k), frightened, 1);
            check_val($sformatf("pacf@%0d", k), pac_move_en, (k % 4 == 3));
            check_val($sformatf("ghostf@%0d", k), ghost_move_en, (k == 23 || k == 31));
            if (ghost_move_en) gcount++;
            step();
        end
        ghost_hit = 1'b0;
        check_val("ghost_half_rate", gcount, 2);
        check_val("bonus_score", score, 260);
        check_val("bonus_state", state, 2);
        check_val("fright_cleared", frightened, 0);

        // Hit and pause together while unfrightened: death wins
        ghost_hit = 1'b1; pause = 1'b1; step(); ghost_hit = 1'b0; pause = 1'b0;
        check_val("death_state", state, 4);
        wait_state(3'd1, 20);
        check_val("death1_exit_k", k, 40);
        check_val("death1_lives", lives, 1);
        wait_state(3'd2, 20);
        check_val("replay_k", k, 48);
        ghost_hit = 1'b1; step(); ghost_hit = 1'b0;
        check_val("death2_state", state, 4);
        wait_state(3'd6, 20);
        check_val("gameover_k", k, 56);
        check_val("gameover_lives", lives, 0);

        // Restart; a start pulse in READY must not reload the phase counter
        start = 1'b1; step(); start = 1'b0;
        check_val("restart_state", state, 1);
        check_val("restart_score", score, 0);
        step(); step();
        start = 1'b1; step(); start = 1'b0;
        wait_state(3'd2, 20);
        check_val("restart_play_k", k, 64);

        dot_eaten = 1'b1; step();
        power_eaten = 1'b1; step(); dot_eaten = 1'b0; power_eaten = 1'b0;
        check_val("both_score", score, 60);
        check_val("both_dots", dots_left, 1);
        start = 1'b1; step(); start = 1'b0;
        check_val("play_start_ign", score, 60);
        dot_eaten = 1'b1; step(); dot_eaten = 1'b0;
        check_val("last_dot_dots", dots_left, 0);
        check_val("last_dot_score", score, 70);
        dot_eaten = 1'b1; pause = 1'b1; step(); dot_eaten = 1'b0; pause = 1'b0;
        check_val("lvlclr_state", state, 5);
        check_val("lvlclr_score", score, 70);
        wait_state(3'd1, 20);
        check_val("lvlclr_exit_k", k, 76);
        check_val("lvl2_level", level, 2);
        check_val("lvl2_dots", dots_left, 3);
        wait_state(3'd2, 20);
        check_val("lvl2_play_k", k, 84);

        // Pause freezes everything; fright count (3) resumes afterwards
        pause = 1'b1; step(); pause = 1'b0;
        while (k < 100) begin
            dot_eaten = (k == 86);
            check_val($sformatf("paused@%0d", k), state, 3);
            check_val($sformatf("pac_p@%0d", k), pac_move_en, 0);
            check_val($sformatf("ghost_p@%0d", k), ghost_move_en, 0);
            step();
        end
        dot_eaten = 1'b0;
        check_val("pause_dots", dots_left, 3);
        check_val("pause_fright", frightened, 1);
        pause = 1'b1; step(); pause = 1'b0;
        check_val("resume_state", state, 2);
        while (k < 111) step();
        check_val("fright_k111", frightened, 1);
        step();
        check_val("fright_k112", frightened, 0);

        pause = 1'b1; step(); pause = 1'b0;
        check_val("pause2_state", state, 3);
        reset = 1'b1;
        #1;
        check_val("mid_rst_state", state, 0);
        check_val("mid_rst_score", score, 0);
        check_val("mid_rst_lives", lives, 0);
        check_val("mid_rst_level", level, 0);
        check_val("mid_rst_dots", dots_left, 0);
        check_val("mid_rst_fright", frightened, 0);
        check_val("mid_rst_pac", pac_move_en, 0);
        check_val("mid_rst_ghost", ghost_move_en, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
